// File: rtl/sbox_ctrl_pkg.sv
// rtl/sbox_ctrl_pkg.sv - shared state encoding and default sizes for the S-box layer controller
package sbox_ctrl_pkg;

    localparam int NNIB_DEF   = 16;
    localparam int NSTAGE_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sbox_vld_pipe.sv
// rtl/sbox_vld_pipe.sv - valid tracker mirroring the occupancy of the masked S-box pipeline
module sbox_vld_pipe #(
    parameter int NSTAGE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              adv,
    input  logic              din,
    output logic [NSTAGE-1:0] vld
);

    // Shifts only when the S-box stages advance, so a stall freezes the tokens with the shares.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            vld <= '0;
        end else if (adv) begin
            vld <= {vld[NSTAGE-2:0], din};
        end
    end

endmodule

// File: rtl/sbox_layer_ctrl.sv
// rtl/sbox_layer_ctrl.sv - sequences one masked S-box layer through a shared stallable pipeline
module sbox_layer_ctrl
    import sbox_ctrl_pkg::*;
#(
    parameter int NNIB   = NNIB_DEF,
    parameter int NSTAGE = NSTAGE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rnd_valid,
    output logic              rnd_req,
    output logic              feed_en,
    output logic [3:0]        feed_idx,
    output logic [NSTAGE-1:0] stage_en,
    output logic              wr_en,
    output logic [3:0]        wr_idx,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(NNIB + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   feed_cnt_q, feed_cnt_d;
    logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [NSTAGE-1:0] vld;
    logic            adv;
    logic            vld_clr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            feed_cnt_q <= '0;
            wr_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            feed_cnt_q <= feed_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    // Outputs are qualified by rst_n so nothing leaks out while reset is held.
    always_comb begin
        state_d    = state_q;
        feed_cnt_d = feed_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        vld_clr    = 1'b0;

        busy     = rst_n && (state_q == ST_RUN);
        rnd_req  = busy;
        done     = rst_n && (state_q == ST_DONE);
        adv      = busy && rnd_valid;
        stage_en = {NSTAGE{adv}};
        feed_en  = adv && (feed_cnt_q < CW'(NNIB));
        wr_en    = adv && vld[NSTAGE-1];
        feed_idx = rst_n ? 4'(feed_cnt_q) : 4'd0;
        wr_idx   = rst_n ? 4'(wr_cnt_q) : 4'd0;

        if (feed_en) begin
            feed_cnt_d = feed_cnt_q + CW'(1);
        end
        if (wr_en) begin
            wr_cnt_d = wr_cnt_q + CW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    feed_cnt_d = '0;
                    wr_cnt_d   = '0;
                    vld_clr    = 1'b1;
                end
            end
            ST_RUN: begin
                if (wr_en && (wr_cnt_q == CW'(NNIB - 1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    sbox_vld_pipe #(
        .NSTAGE(NSTAGE)
    ) u_vld_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (vld_clr),
        .adv   (adv),
        .din   (feed_en),
        .vld   (vld)
    );

endmodule

// File: tb/tb_sbox_layer_ctrl.sv
// tb/tb_sbox_layer_ctrl.sv - randomized and directed bench for sbox_layer_ctrl against an advance-count model
module tb_sbox_layer_ctrl;

    localparam int NN = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, rnd_valid;

    logic       rnd_req_a, feed_en_a, wr_en_a, busy_a, done_a;
    logic [3:0] feed_idx_a, wr_idx_a;
    logic [3:0] stage_en_a;

    logic       rnd_req_b, feed_en_b, wr_en_b, busy_b, done_b;
    logic [3:0] feed_idx_b, wr_idx_b;
    logic [1:0] stage_en_b;

    sbox_layer_ctrl dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rnd_valid (rnd_valid),
        .rnd_req   (rnd_req_a),
        .feed_en   (feed_en_a),
        .feed_idx  (feed_idx_a),
        .stage_en  (stage_en_a),
        .wr_en     (wr_en_a),
        .wr_idx    (wr_idx_a),
        .busy      (busy_a),
        .done      (done_a)
    );

    sbox_layer_ctrl #(.NNIB(16), .NSTAGE(2)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rnd_valid (rnd_valid),
        .rnd_req   (rnd_req_b),
        .feed_en   (feed_en_b),
        .feed_idx  (feed_idx_b),
        .stage_en  (stage_en_b),
        .wr_en     (wr_en_b),
        .wr_idx    (wr_idx_b),
        .busy      (busy_b),
        .done      (done_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;
    int ns_of [2];
    int m_ph [2];     // 0 idle, 1 run, 2 done
    int m_adv [2];    // advancing cycles seen in the current layer
    int sb_next [2];
    int done_cyc [2];
    int first_wr_cyc [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_dut(input int d);
        int          ns;
        logic        busy_o, rr_o, fe_o, we_o, dn_o;
        logic [3:0]  fi_o, wi_o;
        logic [31:0] se_o;
        bit          run, adv, e_fe, e_we;
        string       p;
        ns = ns_of[d];
        p  = (d == 0) ? "a_" : "b_";
        if (d == 0) begin
            busy_o = busy_a; rr_o = rnd_req_a; fe_o = feed_en_a; we_o = wr_en_a; dn_o = done_a;
            fi_o = feed_idx_a; wi_o = wr_idx_a; se_o = 32'(stage_en_a);
        end else begin
            busy_o = busy_b; rr_o = rnd_req_b; fe_o = feed_en_b; we_o = wr_en_b; dn_o = done_b;
            fi_o = feed_idx_b; wi_o = wr_idx_b; se_o = 32'(stage_en_b);
        end
        run  = rst_n && (m_ph[d] == 1);
        adv  = run && rnd_valid;
        e_fe = adv && (m_adv[d] < NN);
        e_we = adv && (m_adv[d] >= ns) && (m_adv[d] - ns < NN);

        chk({p, "busy"},     32'(busy_o), 32'(run));
        chk({p, "rnd_req"},  32'(rr_o),   32'(run));
        chk({p, "stage_en"}, se_o,        adv ? ((32'd1 << ns) - 32'd1) : 32'd0);
        chk({p, "feed_en"},  32'(fe_o),   32'(e_fe));
        chk({p, "wr_en"},    32'(we_o),   32'(e_we));
        chk({p, "done"},     32'(dn_o),   32'(rst_n && (m_ph[d] == 2)));
        if (e_fe) chk({p, "feed_idx"}, 32'(fi_o), 32'(m_adv[d]));
        if (e_we) chk({p, "wr_idx"},   32'(wi_o), 32'(m_adv[d] - ns));
        if (!rst_n) begin
            chk({p, "rst_feed_idx"}, 32'(fi_o), 32'd0);
            chk({p, "rst_wr_idx"},   32'(wi_o), 32'd0);
        end
        if (we_o) begin
            chk({p, "sb_order"},  32'(wi_o),    32'(sb_next[d]));
            chk({p, "sb_wr_adv"}, 32'(se_o[0]), 32'd1);
            sb_next[d]++;
            if (first_wr_cyc[d] < 0) first_wr_cyc[d] = cyc;
        end
        if (dn_o) begin
            chk({p, "sb_count"}, 32'(sb_next[d]), 32'(NN));
            done_cyc[d] = cyc;
        end
    endtask

    task automatic update_model(input int d);
        bit adv;
        adv = (m_ph[d] == 1) && rnd_valid;
        if (!rst_n) begin
            m_ph[d]  = 0;
            m_adv[d] = 0;
        end else begin
            case (m_ph[d])
                0: if (start) begin
                    m_ph[d]    = 1;
                    m_adv[d]   = 0;
                    sb_next[d] = 0;
                end
                1: if (adv) begin
                    if (m_adv[d] - ns_of[d] == NN - 1) m_ph[d] = 2;
                    m_adv[d]++;
                end
                default: m_ph[d] = 0;
            endcase
        end
    endtask

    task automatic run_cycle(input logic s, input logic rv, input logic rn);
        start     = s;
        rnd_valid = rv;
        rst_n     = rn;
        @(negedge clk);
        check_dut(0);
        check_dut(1);
        update_model(0);
        update_model(1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic begin_scenario();
        run_cycle(1'b0, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0);
        cyc = 0;
        for (int d = 0; d < 2; d++) begin
            done_cyc[d]     = -1;
            first_wr_cyc[d] = -1;
        end
    endtask

    initial begin
        ns_of[0] = 4;
        ns_of[1] = 2;
        for (int d = 0; d < 2; d++) begin
            m_ph[d] = 0; m_adv[d] = 0; sb_next[d] = 0;
        end
        cyc = 0;
        start = 1'b0; rnd_valid = 1'b0; rst_n = 1'b0;

        // full-rate layer, both pipeline depths
        begin_scenario();
        run_cycle(1'b1, 1'b1, 1'b1);
        for (int c = 1; c < 25; c++) run_cycle(1'b0, 1'b1, 1'b1);
        chk("s1_first_wr_a", 32'(first_wr_cyc[0]), 32'd5);
        chk("s1_done_a",     32'(done_cyc[0]),     32'd21);
        chk("s1_first_wr_b", 32'(first_wr_cyc[1]), 32'd3);
        chk("s1_done_b",     32'(done_cyc[1]),     32'd19);

        // randomness stall in cycles 3-5
        begin_scenario();
        run_cycle(1'b1, 1'b1, 1'b1);
        for (int c = 1; c < 28; c++) run_cycle(1'b0, !(c >= 3 && c <= 5), 1'b1);
        chk("s2_first_wr_a", 32'(first_wr_cyc[0]), 32'd8);
        chk("s2_done_a",     32'(done_cyc[0]),     32'd24);
        chk("s2_done_b",     32'(done_cyc[1]),     32'd22);

        // start held high: next layer only accepted from idle
        begin_scenario();
        for (int c = 0; c < 44; c++) run_cycle(1'b1, 1'b1, 1'b1);
        chk("s3_done2_a", 32'(done_cyc[0]), 32'd43);

        // reset mid-layer, then a clean restart
        begin_scenario();
        run_cycle(1'b1, 1'b1, 1'b1);
        for (int c = 1; c < 10; c++) run_cycle(1'b0, 1'b1, 1'b1);
        run_cycle(1'b0, 1'b1, 1'b0);
        for (int c = 11; c < 14; c++) run_cycle(1'b0, 1'b1, 1'b1);
        chk("s4_no_done_a", 32'(done_cyc[0]), 32'hffff_ffff);
        run_cycle(1'b1, 1'b1, 1'b1);
        for (int c = 15; c < 40; c++) run_cycle(1'b0, 1'b1, 1'b1);
        chk("s4_done_a", 32'(done_cyc[0]), 32'd35);
        chk("s4_done_b", 32'(done_cyc[1]), 32'd33);

        // random traffic with stalls, restarts and occasional resets
        begin_scenario();
        for (int c = 0; c < 1500; c++) begin
            run_cycle(1'($urandom_range(0, 7) == 0),
                      1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 199) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
